ac97_frame_tx: RTL and testbench
================================

AC97_FRAME_TX -- requirements
Module: ac97_frame_tx

Interface
REQ-001 BIT_CLK  in  1  serial bit clock (12.288 MHz); all state changes on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-003 enable  in  1  link enable; low holds the link idle.
REQ-004 sampleIn  in  20  PCM sample, sent identically in slot 3 (left) and slot 4 (right).
REQ-005 frameMax  in  11  frameCount modulus; 0 treated as 1.
REQ-006 cmdValid  in  1  register-write request.
REQ-007 cmdAddr  in  7  codec register index.
REQ-008 cmdData  in  16  codec register data.
REQ-009 cmdReady  out  1  high when no command is pending or active.
REQ-010 SYNC  out  1  AC'97 frame sync.
REQ-011 SDATA_OUT  out  1  AC'97 serial data, MSB first.
REQ-012 frame  out  1  one-cycle strobe during last bit (position 255) of every frame.
REQ-013 frameCount  out  11  frame index, 0..frameMax-1.

Function
REQ-014 SHALL keep bitPos counter 0..255, incrementing on each rising edge with enable high, wrapping 255->0.
REQ-015 SHALL register SYNC and SDATA_OUT so that they present bit p during the cycle after the edge loading bitPos = p.
REQ-016 SYNC SHALL be 1 for bitPos 0..15, 0 for 16..255.
REQ-017 Slot map: slot0 tag bits 0..15, slot1 16..35, slot2 36..55, slot3 56..75, slot4 76..95, bits 96..255 all 0.
REQ-018 Tag: bit15 = 1, bit14 = slot1 valid, bit13 = slot2 valid, bit12 = bit11 = 1, bits 10..0 = 0; MSB at bitPos 0.
REQ-019 Slot1 = {1'b0 (write), cmdAddr[6:0], 12'b0}; slot2 = {cmdData[15:0], 4'b0}; both all-zero with tag bits 14/13 = 0 when no command is active.
REQ-020 Slots 3 and 4 SHALL each carry the 20-bit sample latched for that frame, MSB first.
REQ-021 On the edge loading bitPos = 0, SHALL latch sampleIn into a shadow register; sampleIn changes at other times do not affect the frame in flight.
REQ-022 Command handshake: accept when cmdValid && cmdReady at a rising edge; capture addr/data into pending register; cmdReady low next cycle.
REQ-023 Pending command SHALL become active on the next edge loading bitPos = 0, used for that whole frame, cleared at edge loading bitPos = 56; cmdReady returns high on that edge.
REQ-024 A command accepted on the same edge that loads bitPos = 0 SHALL wait for the following frame.
REQ-025 frame SHALL be 1 exactly while bitPos = 255, else 0.
REQ-026 frameCount SHALL increment on the edge loading bitPos = 0, wrapping from frameMax-1 to 0; value >= frameMax after a frameMax change SHALL wrap to 0 at next increment.
REQ-027 enable low: bitPos, frameCount, pending command held; SYNC, SDATA_OUT, frame forced 0 next cycle; cmdReady unchanged.
REQ-028 enable rising mid-frame SHALL resume from held bitPos; no frame restart.

Reset
REQ-029 RESET_N low SHALL immediately force bitPos = 255, frameCount = 0, SYNC = 0, SDATA_OUT = 0, frame = 0, cmdReady = 1, shadow sample = 0, pending/active command cleared.
REQ-030 After RESET_N release with enable high, the first rising edge SHALL start frame 0 (bitPos 0), frameCount remains 0 for that first frame.
REQ-031 Reset asserted mid-frame SHALL abandon frame and any accepted command.

Verification
REQ-032 Reset, enable=1, sampleIn=20'hABCDE, no cmd -> SYNC high 16 bits every 256; tag bits 0..15 = 16'h9800; bits 56..75 and 76..95 = 20'hABCDE; bits 16..55 and 96..255 = 0.
REQ-033 cmdValid with addr 7'h02, data 16'h0808 mid-frame -> cmdReady low next cycle; next frame tag = 16'hF800, slot1 = 20'h02000, slot2 = 20'h08080; cmdReady high at bitPos 56.
REQ-034 frameMax=4 -> frameCount 0,1,2,3,0; frame pulse once per 256 clocks at bitPos 255.
REQ-035 sampleIn changed at bitPos 60 -> current frame slots 3/4 keep old value; new value sent next frame.
REQ-036 enable low at bitPos 100 for 50 cycles -> SYNC/SDATA_OUT/frame 0; on re-enable, resumes at bitPos 101.
REQ-037 RESET_N pulsed at bitPos 40 with command active -> outputs 0 immediately, cmdReady = 1; next frame tag = 16'h9800.

Source files
------------

// File: rtl/ac97_frame_tx_if.sv
// Codec register-write command channel: one valid/ready handshake carrying a
// single AC'97 register write (address + data).
interface ac97_frame_tx_if;
    logic        cmdValid;
    logic [6:0]  cmdAddr;
    logic [15:0] cmdData;
    logic        cmdReady;

    modport master (output cmdValid, output cmdAddr, output cmdData, input cmdReady);
    modport slave  (input cmdValid, input cmdAddr, input cmdData, output cmdReady);
endinterface

// File: rtl/ac97_frame_tx.sv
// AC'97 output-frame serializer: 256-bit frames with SYNC, tag, one register
// write (slots 1/2) and a shadowed PCM sample duplicated into slots 3/4.
module ac97_frame_tx (
    input  logic           BIT_CLK,
    input  logic           RESET_N,
    input  logic           enable,
    input  logic [19:0]    sampleIn,
    input  logic [10:0]    frameMax,
    ac97_frame_tx_if.slave cmd,
    output logic           SYNC,
    output logic           SDATA_OUT,
    output logic           frame,
    output logic [10:0]    frameCount
);
    localparam logic [7:0] LAST_POS    = 8'd255;
    localparam logic [7:0] SYNC_LEN    = 8'd16;
    localparam logic [7:0] SLOT2_END   = 8'd55;
    localparam logic [7:0] PAYLOAD_LEN = 8'd96;

    logic [7:0]  bitPosReg;
    logic [7:0]  bitPosNext;
    logic [10:0] frameCountReg;
    logic [10:0] frameCountNext;
    logic        firstFrameReg;
    logic [19:0] shadowReg;
    logic        pendValidReg;
    logic [6:0]  pendAddrReg;
    logic [15:0] pendDataReg;
    logic        actValidReg;
    logic [6:0]  actAddrReg;
    logic [15:0] actDataReg;
    logic        syncReg;
    logic        sdataReg;
    logic        frameReg;

    logic        readyInt;
    logic        cmdAccept;
    logic        frameStart;
    logic        slotsDone;
    logic [10:0] frameMaxEff;
    logic [11:0] countInc;
    logic [15:0] tagWord;
    logic [19:0] slot1Word;
    logic [19:0] slot2Word;
    logic [95:0] payloadWord;
    logic [95:0] payloadByPos;
    logic        dataBit;

    assign readyInt     = !pendValidReg && !actValidReg;
    assign cmd.cmdReady = readyInt;
    assign cmdAccept    = cmd.cmdValid && readyInt;

    // Edges that load bitPos = 0 and bitPos = 56 respectively.
    assign frameStart = enable && (bitPosReg == LAST_POS);
    assign slotsDone  = enable && (bitPosReg == SLOT2_END);
    assign bitPosNext = bitPosReg + 8'd1;

    // Compare rather than test equality so a count stranded above a reduced
    // modulus still wraps to zero on its next increment.
    assign frameMaxEff    = (frameMax == 11'd0) ? 11'd1 : frameMax;
    assign countInc       = {1'b0, frameCountReg} + 12'd1;
    assign frameCountNext = (countInc >= {1'b0, frameMaxEff}) ? 11'd0 : countInc[10:0];

    assign tagWord     = {1'b1, actValidReg, actValidReg, 2'b11, 11'd0};
    assign slot1Word   = actValidReg ? {1'b0, actAddrReg, 12'd0} : 20'd0;
    assign slot2Word   = actValidReg ? {actDataReg, 4'd0} : 20'd0;
    assign payloadWord = {tagWord, slot1Word, slot2Word, shadowReg, shadowReg};

    // Re-index the payload so bit position p selects entry p directly.
    genvar gi;
    generate
        for (gi = 0; gi < 96; gi++) begin : g_bitmap
            assign payloadByPos[gi] = payloadWord[95 - gi];
        end
    endgenerate

    assign dataBit = (bitPosNext < PAYLOAD_LEN) ? payloadByPos[bitPosNext[6:0]] : 1'b0;

    always_ff @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bitPosReg     <= LAST_POS;
            frameCountReg <= 11'd0;
            firstFrameReg <= 1'b1;
            shadowReg     <= 20'd0;
            pendValidReg  <= 1'b0;
            pendAddrReg   <= 7'd0;
            pendDataReg   <= 16'd0;
            actValidReg   <= 1'b0;
            actAddrReg    <= 7'd0;
            actDataReg    <= 16'd0;
            syncReg       <= 1'b0;
            sdataReg      <= 1'b0;
            frameReg      <= 1'b0;
        end else begin
            if (enable) begin
                bitPosReg <= bitPosNext;
                syncReg   <= (bitPosNext < SYNC_LEN);
                sdataReg  <= dataBit;
                frameReg  <= (bitPosNext == LAST_POS);
            end else begin
                syncReg  <= 1'b0;
                sdataReg <= 1'b0;
                frameReg <= 1'b0;
            end

            if (frameStart) begin
                shadowReg     <= sampleIn;
                firstFrameReg <= 1'b0;
                if (!firstFrameReg) begin
                    frameCountReg <= frameCountNext;
                end
            end

            // Promotion uses the pending flag from before this edge, so a
            // command accepted on the frame-start edge waits one more frame.
            if (frameStart && pendValidReg) begin
                actValidReg  <= 1'b1;
                actAddrReg   <= pendAddrReg;
                actDataReg   <= pendDataReg;
                pendValidReg <= 1'b0;
            end else if (slotsDone) begin
                actValidReg <= 1'b0;
            end

            if (cmdAccept) begin
                pendValidReg <= 1'b1;
                pendAddrReg  <= cmd.cmdAddr;
                pendDataReg  <= cmd.cmdData;
            end
        end
    end

    assign SYNC       = syncReg;
    assign SDATA_OUT  = sdataReg;
    assign frame      = frameReg;
    assign frameCount = frameCountReg;
endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: directed frame checks against literal values plus
// randomized traffic compared each cycle against a slot-level reference model.
module tb_ac97_frame_tx;
    logic        BIT_CLK = 1'b0;
    logic        RESET_N;
    logic        enable;
    logic [19:0] sampleIn;
    logic [10:0] frameMax;
    logic        SYNC;
    logic        SDATA_OUT;
    logic        frame;
    logic [10:0] frameCount;

    ac97_frame_tx_if cmdBus();

    ac97_frame_tx dut (
        .BIT_CLK   (BIT_CLK),
        .RESET_N   (RESET_N),
        .enable    (enable),
        .sampleIn  (sampleIn),
        .frameMax  (frameMax),
        .cmd       (cmdBus),
        .SYNC      (SYNC),
        .SDATA_OUT (SDATA_OUT),
        .frame     (frame),
        .frameCount(frameCount)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          mPos      = 255;
    int          mCount    = 0;
    bit          mFirst    = 1'b1;
    logic [19:0] mShadow   = 20'd0;
    bit          mPend     = 1'b0;
    bit          mAct      = 1'b0;
    logic [6:0]  mPendAddr = 7'd0;
    logic [6:0]  mActAddr  = 7'd0;
    logic [15:0] mPendData = 16'd0;
    logic [15:0] mActData  = 16'd0;
    bit          mSync     = 1'b0;
    bit          mSdata    = 1'b0;
    bit          mFrame    = 1'b0;
    bit          mOutValid = 1'b0;
    bit          chkOn     = 1'b0;
    bit          capData [0:255];
    bit          capSync [0:255];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Serial bit for frame position p, from the slot layout.
    function automatic bit expBit(input int p, input logic [19:0] smp, input bit act,
                                  input logic [6:0] a, input logic [15:0] d);
        logic [15:0] tag;
        logic [19:0] field;
        int          slot;
        int          k;
        if (p < 16) begin
            tag = 16'h8000 + 16'h1000 + 16'h0800 + (act ? 16'h6000 : 16'h0000);
            return tag[15 - p];
        end
        if (p < 96) begin
            slot = (p - 16) / 20 + 1;
            k    = (p - 16) % 20;
            case (slot)
                1:       field = act ? {1'b0, a, 12'h000} : 20'h0;
                2:       field = act ? {d, 4'h0} : 20'h0;
                default: field = smp;
            endcase
            return field[19 - k];
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        mPos = 255; mCount = 0; mFirst = 1'b1; mShadow = 20'd0;
        mPend = 1'b0; mAct = 1'b0;
        mSync = 1'b0; mSdata = 1'b0; mFrame = 1'b0; mOutValid = 1'b0;
    endtask

    task automatic modelEdge();
        bit accept;
        int np;
        int fmax;
        accept = cmdBus.cmdValid && !mPend && !mAct;
        if (enable) begin
            np = (mPos + 1) % 256;
            if (np == 0) begin
                mShadow = sampleIn;
                if (mFirst) begin
                    mFirst = 1'b0;
                end else begin
                    fmax   = (frameMax == 11'd0) ? 1 : int'(frameMax);
                    mCount = (mCount + 1 >= fmax) ? 0 : mCount + 1;
                end
                if (mPend) begin
                    mAct = 1'b1; mActAddr = mPendAddr; mActData = mPendData; mPend = 1'b0;
                end
            end
            if (np == 56) mAct = 1'b0;
            mPos      = np;
            mSync     = (np < 16);
            mSdata    = expBit(np, mShadow, mAct, mActAddr, mActData);
            mFrame    = (np == 255);
            mOutValid = 1'b1;
        end else begin
            mSync = 1'b0; mSdata = 1'b0; mFrame = 1'b0; mOutValid = 1'b0;
        end
        if (accept) begin
            mPend = 1'b1; mPendAddr = cmdBus.cmdAddr; mPendData = cmdBus.cmdData;
            $display("cmd accepted: addr=%h data=%h", cmdBus.cmdAddr, cmdBus.cmdData);
        end
    endtask

    always @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) modelReset();
        else          modelEdge();
    end

    always @(negedge BIT_CLK) begin
        if (chkOn) begin
            chk("SYNC", SYNC, mSync);
            chk("SDATA_OUT", SDATA_OUT, mSdata);
            chk("frame", frame, mFrame);
            chk("frameCount", frameCount, mCount);
            chk("cmdReady", cmdBus.cmdReady, !mPend && !mAct);
            if (mOutValid) begin
                capData[mPos] = SDATA_OUT;
                capSync[mPos] = SYNC;
            end
        end
    end

    task automatic step();
        @(posedge BIT_CLK);
        #2;
    endtask

    task automatic runTo(input int target);
        int n = 0;
        do begin
            step();
            n++;
        end while (mPos != target && n < 1000);
        if (mPos != target) chk("runTo_timeout", mPos, target);
    endtask

    function automatic logic [31:0] capField(input int lo, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = {v[30:0], capData[lo + i]};
        return v;
    endfunction

    // Called right after the edge loading bitPos 255.
    task automatic checkFrame(input logic [15:0] eTag, input logic [19:0] eS1,
                              input logic [19:0] eS2, input logic [19:0] eS34, input int eCnt);
        int syncOnes = 0;
        int syncHead = 0;
        int tailOnes = 0;
        @(negedge BIT_CLK);
        #1;
        for (int i = 0; i < 256; i++) begin
            syncOnes += int'(capSync[i]);
            if (i < 16)  syncHead += int'(capSync[i]);
            if (i >= 96) tailOnes += int'(capData[i]);
        end
        chk("tag", capField(0, 16), eTag);
        chk("slot1", capField(16, 20), eS1);
        chk("slot2", capField(36, 20), eS2);
        chk("slot3", capField(56, 20), eS34);
        chk("slot4", capField(76, 20), eS34);
        chk("tail_zero", tailOnes, 0);
        chk("sync_len", syncOnes, 16);
        chk("sync_head", syncHead, 16);
        chk("frame_pulse", frame, 1);
        chk("frame_count", frameCount, eCnt);
        $display("frame count=%0d tag=%h slot1=%h slot2=%h slot3=%h slot4=%h", frameCount,
                 capField(0, 16), capField(16, 20), capField(36, 20), capField(56, 20), capField(76, 20));
    endtask

    initial begin
        int n;
        enable = 1'b1;
        sampleIn = 20'hABCDE;
        frameMax = 11'd4;
        cmdBus.cmdValid = 1'b0;
        cmdBus.cmdAddr  = 7'd0;
        cmdBus.cmdData  = 16'd0;
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        chkOn = 1'b1;
        #1;
        chk("rst_SYNC", SYNC, 0);
        chk("rst_SDATA", SDATA_OUT, 0);
        chk("rst_frame", frame, 0);
        chk("rst_count", frameCount, 0);
        chk("rst_ready", cmdBus.cmdReady, 1);
        step();
        step();
        RESET_N = 1'b1;

        // Frame 0: idle link with a sample.
        runTo(255);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'hABCDE, 0);

        // Frame 1: accept a register write mid-frame.
        runTo(100);
        cmdBus.cmdValid = 1'b1; cmdBus.cmdAddr = 7'h02; cmdBus.cmdData = 16'h0808;
        step();
        cmdBus.cmdValid = 1'b0;
        chk("ready_after_accept", cmdBus.cmdReady, 0);
        runTo(255);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'hABCDE, 1);

        // Frame 2: command in flight; sample changes at bit 60.
        runTo(55);
        chk("ready_at_55", cmdBus.cmdReady, 0);
        step();
        chk("ready_at_56", cmdBus.cmdReady, 1);
        runTo(60);
        sampleIn = 20'h12345;
        runTo(255);
        checkFrame(16'hF800, 20'h02000, 20'h08080, 20'hABCDE, 2);

        // Frame 3: new sample appears.
        runTo(255);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'h12345, 3);

        // Frame 4: enable dropped at bit 100 for 50 cycles.
        runTo(100);
        enable = 1'b0;
        repeat (50) step();
        chk("dis_SYNC", SYNC, 0);
        chk("dis_SDATA", SDATA_OUT, 0);
        chk("dis_frame", frame, 0);
        chk("dis_count", frameCount, 0);
        enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 300);
        chk("resume_len", n, 155);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'h12345, 0);

        // Frame 5: command accepted on the frame-start edge waits a frame.
        cmdBus.cmdValid = 1'b1; cmdBus.cmdAddr = 7'h55; cmdBus.cmdData = 16'hBEEF;
        step();
        cmdBus.cmdValid = 1'b0;
        chk("ready_after_accept2", cmdBus.cmdReady, 0);
        runTo(255);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'h12345, 1);

        // Frame 6: reset at bit 40 while the command is active.
        runTo(20);
        chk("ready_active", cmdBus.cmdReady, 0);
        runTo(40);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_SYNC", SYNC, 0);
        chk("mid_rst_SDATA", SDATA_OUT, 0);
        chk("mid_rst_frame", frame, 0);
        chk("mid_rst_ready", cmdBus.cmdReady, 1);
        chk("mid_rst_count", frameCount, 0);
        step();
        step();
        RESET_N = 1'b1;
        runTo(255);
        checkFrame(16'h9800, 20'h0, 20'h0, 20'h12345, 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 6000; c++) begin
            enable          = ($urandom_range(15) != 0);
            cmdBus.cmdValid = ($urandom_range(7) == 0);
            cmdBus.cmdAddr  = 7'($urandom);
            cmdBus.cmdData  = 16'($urandom);
            if ($urandom_range(31) == 0)   sampleIn = 20'($urandom);
            if ($urandom_range(511) == 0)  frameMax = 11'($urandom_range(5));
            RESET_N = ($urandom_range(2999) != 0);
            step();
        end
        RESET_N = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
